// File: rtl/mb_tx_flit_scheduler.sv
// mb_tx_flit_scheduler: shares the mainband TX among NUM_REQ flit sources.
// Define MB_SCHED_RR_EN for round-robin arbitration; fixed priority otherwise.
module mb_tx_flit_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int CREDITS = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*512-1:0]     data_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic                       mb_valid_o,
  input  logic                       mb_valid_ack_i,
  output logic [511:0]               mb_data_o,
  input  logic                       credit_return_i,
  output logic [$clog2(CREDITS):0]   credits_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic                       credit_err_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(CREDITS) + 1;
  localparam int FW = 512;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic               valid_q, valid_d;
  logic [FW-1:0]      data_q, data_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic [IW-1:0]      gid_q, gid_d;
  logic               err_q, err_d;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic               grant;

`ifdef MB_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] rr_idx;

  // Walk offsets high to low so the one nearest the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rr_idx = IW'((int'(ptr_q) + i) % NUM_REQ);
      if (req_i[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      if (win_idx == IW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = win_idx + IW'(1);
      end
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end
`endif

  assign grant = (state_q == IDLE) && enable_i && win_found
              && (credits_q != '0) && !mb_valid_ack_i;

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    data_d    = data_q;
    gid_d     = gid_q;
    req_ack_d = '0;
    credits_d = credits_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d            = SEND;
          valid_d            = 1'b1;
          data_d             = data_i[win_idx*FW +: FW];
          gid_d              = win_idx;
          req_ack_d[win_idx] = 1'b1;
        end
      end
      SEND: begin
        if (mb_valid_ack_i) begin
          state_d = RELEASE;
          valid_d = 1'b0;
        end
      end
      RELEASE: begin
        if (!mb_valid_ack_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A return at full count is bogus: saturate and flag it.
    if (grant && !credit_return_i) begin
      credits_d = credits_q - CW'(1);
    end else if (!grant && credit_return_i && credits_q != CRED_MAX) begin
      credits_d = credits_q + CW'(1);
    end
    if (credit_return_i && credits_q == CRED_MAX) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_ack_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      credits_q <= CRED_MAX;
      gid_q     <= '0;
      err_q     <= 1'b0;
`ifdef MB_SCHED_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_ack_q <= req_ack_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      credits_q <= credits_d;
      gid_q     <= gid_d;
      err_q     <= err_d;
`ifdef MB_SCHED_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign req_ack_o    = req_ack_q;
  assign mb_valid_o   = valid_q;
  assign mb_data_o    = data_q;
  assign credits_o    = credits_q;
  assign grant_id_o   = gid_q;
  assign credit_err_o = err_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_mb_tx_flit_scheduler.sv
// tb_mb_tx_flit_scheduler: directed bench for mb_tx_flit_scheduler.
// Bench acts as requesters, transmitter handshake and credit source.
module tb_mb_tx_flit_scheduler;

  logic          clk;
  logic          reset;
  logic          enable_i;
  logic [1:0]    req_i;
  logic [1023:0] data_i;
  logic [1:0]    req_ack_o;
  logic          mb_valid_o;
  logic          mb_valid_ack_i;
  logic [511:0]  mb_data_o;
  logic          credit_return_i;
  logic [1:0]    credits_o;
  logic [0:0]    grant_id_o;
  logic          busy_o;
  logic          credit_err_o;

  int checks = 0;
  int errors = 0;

  logic [511:0] d0;
  logic [511:0] d1;
  logic [3:0]   arb_exp;
  logic         gexp;

  mb_tx_flit_scheduler #(
    .NUM_REQ(2),
    .CREDITS(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .req_i          (req_i),
    .data_i         (data_i),
    .req_ack_o      (req_ack_o),
    .mb_valid_o     (mb_valid_o),
    .mb_valid_ack_i (mb_valid_ack_i),
    .mb_data_o      (mb_data_o),
    .credit_return_i(credit_return_i),
    .credits_o      (credits_o),
    .grant_id_o     (grant_id_o),
    .busy_o         (busy_o),
    .credit_err_o   (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Ack up for one cycle (optionally with a credit return), then drop it.
  task automatic handshake(input logic ret);
    mb_valid_ack_i  = 1'b1;
    credit_return_i = ret;
    tick();
    credit_return_i = 1'b0;
    mb_valid_ack_i  = 1'b0;
    tick();
  endtask

  initial begin
    d0 = {64{8'hA0}};
    d1 = {64{8'hB1}};
`ifdef MB_SCHED_RR_EN
    arb_exp = 4'b1010;
`else
    arb_exp = 4'b0000;
`endif
    reset           = 1'b1;
    enable_i        = 1'b0;
    req_i           = 2'b00;
    data_i          = {d1, d0};
    mb_valid_ack_i  = 1'b0;
    credit_return_i = 1'b0;
    tick();
    tick();
    chk("rst_valid", mb_valid_o, 1'b0);
    chk("rst_ack", req_ack_o, 2'b00);
    chk("rst_data", mb_data_o, '0);
    chk("rst_gid", grant_id_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err", credit_err_o, 1'b0);
    chk("rst_cred", credits_o, 2'd2);
    reset = 1'b0;
    tick();

    // single flit
    enable_i = 1'b1;
    req_i    = 2'b01;
    tick();
    chk("sf_ack", req_ack_o, 2'b01);
    chk("sf_valid", mb_valid_o, 1'b1);
    chk("sf_busy", busy_o, 1'b1);
    chk("sf_data", mb_data_o, d0);
    chk("sf_gid", grant_id_o, 1'b0);
    chk("sf_cred", credits_o, 2'd1);
    req_i = 2'b00;
    tick();
    chk("sf_ack_pulse", req_ack_o, 2'b00);
    chk("sf_valid_hold", mb_valid_o, 1'b1);
    tick();
    mb_valid_ack_i = 1'b1;
    tick();
    chk("sf_valid_drop", mb_valid_o, 1'b0);
    chk("sf_busy_rel", busy_o, 1'b1);
    tick();
    chk("sf_rel_wait", busy_o, 1'b1);
    mb_valid_ack_i = 1'b0;
    tick();
    chk("sf_idle", busy_o, 1'b0);
    chk("sf_cred_hold", credits_o, 2'd1);
    credit_return_i = 1'b1;
    tick();
    credit_return_i = 1'b0;
    chk("sf_cred_ret", credits_o, 2'd2);

    // credit stall: three requests, two credits
    req_i = 2'b01;
    tick();
    chk("cs_g1_ack", req_ack_o, 2'b01);
    chk("cs_g1_cred", credits_o, 2'd1);
    handshake(1'b0);
    tick();
    chk("cs_g2_ack", req_ack_o, 2'b01);
    chk("cs_g2_cred", credits_o, 2'd0);
    handshake(1'b0);
    tick();
    chk("cs_stall_ack", req_ack_o, 2'b00);
    chk("cs_stall_busy", busy_o, 1'b0);
    chk("cs_stall_cred", credits_o, 2'd0);
    credit_return_i = 1'b1;
    tick();
    credit_return_i = 1'b0;
    chk("cs_ret_cred", credits_o, 2'd1);
    chk("cs_ret_nogrant", req_ack_o, 2'b00);
    tick();
    chk("cs_g3_ack", req_ack_o, 2'b01);
    chk("cs_g3_cred", credits_o, 2'd0);
    req_i = 2'b00;
    handshake(1'b0);
    credit_return_i = 1'b1;
    tick();
    tick();
    credit_return_i = 1'b0;
    chk("cs_refill", credits_o, 2'd2);

    // arbitration from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      gexp = arb_exp[k];
      tick();
      chk($sformatf("arb%0d_gid", k), grant_id_o, gexp);
      chk($sformatf("arb%0d_ack", k), req_ack_o, gexp ? 2'b10 : 2'b01);
      chk($sformatf("arb%0d_data", k), mb_data_o, gexp ? d1 : d0);
      handshake(1'b1);
    end
    req_i = 2'b10;
    tick();
    chk("arb_r1_gid", grant_id_o, 1'b1);
    chk("arb_r1_ack", req_ack_o, 2'b10);
    req_i = 2'b00;
    handshake(1'b1);
    chk("arb_cred", credits_o, 2'd2);

    // simultaneous grant and return at one credit
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    handshake(1'b0);
    chk("sim_pre_cred", credits_o, 2'd1);
    req_i           = 2'b01;
    credit_return_i = 1'b1;
    tick();
    req_i           = 2'b00;
    credit_return_i = 1'b0;
    chk("sim_ack", req_ack_o, 2'b01);
    chk("sim_cred", credits_o, 2'd1);
    handshake(1'b1);
    chk("sim_post_cred", credits_o, 2'd2);

    // credit overflow
    chk("ovf_pre_err", credit_err_o, 1'b0);
    credit_return_i = 1'b1;
    tick();
    credit_return_i = 1'b0;
    chk("ovf_cred", credits_o, 2'd2);
    chk("ovf_err", credit_err_o, 1'b1);
    tick();
    tick();
    chk("ovf_sticky", credit_err_o, 1'b1);

    // enable low blocks grants
    enable_i = 1'b0;
    req_i    = 2'b01;
    tick();
    tick();
    chk("en_ack", req_ack_o, 2'b00);
    chk("en_busy", busy_o, 1'b0);
    enable_i = 1'b1;
    tick();
    chk("en_grant", mb_valid_o, 1'b1);

    // asynchronous reset while in SEND
    reset = 1'b1;
    #1;
    chk("rs_valid", mb_valid_o, 1'b0);
    chk("rs_cred", credits_o, 2'd2);
    chk("rs_busy", busy_o, 1'b0);
    chk("rs_data", mb_data_o, '0);
    chk("rs_err", credit_err_o, 1'b0);
    req_i = 2'b00;
    tick();
    reset = 1'b0;
    tick();
    req_i = 2'b10;
    tick();
    chk("rs_new_ack", req_ack_o, 2'b10);
    chk("rs_new_gid", grant_id_o, 1'b1);
    chk("rs_new_data", mb_data_o, d1);
    chk("rs_new_cred", credits_o, 2'd1);
    req_i = 2'b00;
    handshake(1'b1);
    chk("rs_end_busy", busy_o, 1'b0);
    chk("rs_end_cred", credits_o, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mb_tx_flit_scheduler.md
# mb_tx_flit_scheduler

Flit-side scheduler that shares the mainband transmitter between `NUM_REQ` flit sources (e.g. adapter data and link-training patterns). It arbitrates requests, latches the winning 64-byte flit, and drives the transmitter's valid/ack flit handshake. It also tracks free transmitter flit-buffer slots with a credit counter, so it never launches more flits than the transmitter can hold. It sits in the 100 MHz flit domain, directly upstream of the mainband TX serializer.

## Interface

- `NUM_REQ`, 2: number of requesters (2..4).
- `CREDITS`, 2: transmitter flit-buffer depth; the initial and maximum credit count (power of 2, ≥2).

- `clk`  in  1  flit-domain clock (100 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `enable_i`  in  1  link active; new grants are only made while high.
- `req_i`  in  NUM_REQ  per-requester flit request; held until the matching `req_ack_o`.
- `data_i`  in  NUM_REQ×64×8  per-requester flit, 64 bytes; stable while `req_i` is high.
- `req_ack_o`  out  NUM_REQ  one-cycle pulse: that requester's flit has been latched.
- `mb_valid_o`  out  1  to transmitter `valid_i`.
- `mb_valid_ack_i`  in  1  from transmitter `valid_ack_o` (already in `clk` domain).
- `mb_data_o`  out  64×8  latched flit, to transmitter `data_i`.
- `credit_return_i`  in  1  one-cycle pulse per flit fully serialized (synchronized upstream).
- `credits_o`  out  $clog2(CREDITS)+1  free transmitter slots.
- `grant_id_o`  out  $clog2(NUM_REQ)  source of the flit currently held.
- `busy_o`  out  1  high in any state other than IDLE.
- `credit_err_o`  out  1  sticky; set when a credit return arrives at `credits_o == CREDITS`.

## Operation

- FSM states: IDLE, SEND, RELEASE.
- **IDLE**
  - Grant condition: `enable_i && |req_i && credits_o != 0 && !mb_valid_ack_i`.
  - On grant: pick a winner (see Configuration), latch `data_i[winner]` into `mb_data_o`, set `grant_id_o`, pulse `req_ack_o[winner]`, decrement credits, go to SEND.
- **SEND**
  - `mb_valid_o = 1`, data held stable.
  - On `mb_valid_ack_i == 1`: go to RELEASE.
- **RELEASE**
  - `mb_valid_o = 0`.
  - On `mb_valid_ack_i == 0`: go to IDLE.
  - This is a full 4-phase handshake; the next flit is never offered before the ack drops.
- **Credits**
  - Grant: −1. `credit_return_i`: +1.
  - Both in the same cycle: count unchanged.
  - Return at `CREDITS`: count stays at `CREDITS` and `credit_err_o` sets. Only reset clears it.
  - The count never underflows, because a grant requires credits > 0.
- **enable_i low mid-transfer:** the current SEND/RELEASE handshake completes normally; only new grants are blocked.
- **Unacked requests** stay pending; a requester may not drop `req_i` before its ack.

## Timing

- Reset values:
  - State IDLE.
  - `mb_valid_o = 0`, `req_ack_o = 0`, `mb_data_o = 0`, `grant_id_o = 0`.
  - `busy_o = 0`, `credit_err_o = 0`, `credits_o = CREDITS`.
  - Round-robin pointer points at requester 0.
- Reset mid-transfer: everything returns to the reset values immediately (asynchronous), and the latched flit is discarded.
- Latency:
  - Request seen in IDLE at edge N → `req_ack_o` high and `mb_valid_o` high in cycle N+1.
  - Transfer length: 1 + (cycles until ack rises) + (cycles until ack falls).
- `credits_o` is registered; it reflects a grant or return on the edge after the event.
- With credits = 0 and a `credit_return_i` in an IDLE cycle, the grant occurs on the following cycle, never the same cycle.
- All outputs are registered except `busy_o`, which is decoded from state.

## Configuration

- `MB_SCHED_RR_EN`
  - **Defined:** round-robin arbitration. A pointer advances to (winner+1) mod `NUM_REQ` after each grant, and the search starts at the pointer.
  - **Undefined:** fixed priority, lowest index wins. The pointer logic is not compiled.

## Test plan

- **Single flit:** `req_i = 01`, ack rises 3 cycles after valid and falls 2 later.
  - `req_ack_o[0]` pulses in cycle 1, with `mb_valid_o` high in the same cycle.
  - `mb_valid_o` drops once ack is seen high.
  - `credits_o` goes 2 → 1; returns to IDLE once ack is low.
- **Credit stall:** 3 back-to-back requests with no `credit_return_i`.
  - 2 flits are sent, then `credits_o = 0` and req 3 stays pending.
  - A `credit_return_i` pulse lets req 3 be granted the following cycle.
- **Arbitration:** `req_i = 11` held for 4 flits.
  - With `MB_SCHED_RR_EN`: grants go 0, 1, 0, 1.
  - Without: grants go 0, 0, 0, 0, and requester 1 is starved until requester 0 drops.
- **Simultaneous grant and return** at `credits_o = 1`: `credits_o` stays 1.
- **Credit overflow:** an extra return at `credits_o = 2` keeps `credits_o = 2` and sets `credit_err_o`, which stays set.
- **Reset in SEND:** assert `reset` while `mb_valid_o = 1`.
  - `mb_valid_o` drops immediately, `credits_o = 2`, `busy_o = 0`.
  - A new request after release is granted normally.
